// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and encodings for the decode-stage hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LU_STALL = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    // Bit positions inside ctrl_sig {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp1,ALUOp0}
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP1   = 1;
    localparam int CTRL_ALUOP0   = 0;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // EX/MEM result is newer than MEM/WB, so it is checked first; $0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       mem_rw,
        input logic [4:0] mem_wr,
        input logic       wb_rw,
        input logic [4:0] wb_wr
    );
        if (mem_rw && (mem_wr != 5'd0) && (mem_wr == src)) begin
            return FWD_EXMEM;
        end
        if (wb_rw && (wb_wr != 5'd0) && (wb_wr == src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// Module : forward_unit
// Brief  : Combinational EX-stage operand forwarding selects.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_write_reg,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_write_reg,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_select(ex_rs, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg);
    assign fwd_b = fwd_select(ex_rt, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg);

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module : hazard_controller
// Brief  : Pipeline sequencer: load-use bubbles, branch flushes, memory freeze
//          and forwarding selects, with saturating stall/flush counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_controller
    import hazard_pkg::*;
#(
    parameter int INIT_CYCLES      = 2,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [8:0]       id_ctrl_in,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_branch_taken,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_write_reg,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [8:0]       id_ctrl_out,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int BUB_W  = $clog2(LOAD_USE_BUBBLES + 1);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [BUB_W-1:0]  BUB_TOTAL = BUB_W'(LOAD_USE_BUBBLES);

    state_t              state;
    state_t              state_nxt;
    state_t              ret_state;
    state_t              ret_state_nxt;
    logic [INIT_W-1:0]   init_cnt;
    logic [INIT_W-1:0]   init_cnt_nxt;
    logic [BUB_W-1:0]    bubble_cnt;
    logic [BUB_W-1:0]    bubble_cnt_nxt;
    logic [BUB_W-1:0]    bubble_inc;
    logic                init_mode;
    logic                flush_evt;
    logic                eval_lu;
    logic                uses_rt;
    logic                load_use;
    logic [1:0]          fu_fwd_a;
    logic [1:0]          fu_fwd_b;

    forward_unit u_forward_unit (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_reg_write (mem_reg_write),
        .mem_write_reg (mem_write_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .fwd_a         (fu_fwd_a),
        .fwd_b         (fu_fwd_b)
    );

    assign fwd_a = init_mode ? FWD_RF : fu_fwd_a;
    assign fwd_b = init_mode ? FWD_RF : fu_fwd_b;

    // A frozen LU_STALL resumes its bubble sequence once memory is ready again.
    assign eval_lu  = (state == ST_LU_STALL) ||
                      ((state == ST_MEM_WAIT) && (ret_state == ST_LU_STALL));
    assign uses_rt  = id_ctrl_in[CTRL_REGDST] | id_ctrl_in[CTRL_MEMWRITE] | id_ctrl_in[CTRL_BRANCH];
    assign load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                      ((ex_write_reg == id_rs) || ((ex_write_reg == id_rt) && uses_rt));
    assign bubble_inc = bubble_cnt + BUB_W'(1);

    always_comb begin
        state_nxt      = state;
        ret_state_nxt  = ret_state;
        init_cnt_nxt   = init_cnt;
        bubble_cnt_nxt = bubble_cnt;
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        idex_en        = 1'b0;
        exmem_en       = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        id_ctrl_out    = id_ctrl_in;
        init_mode      = 1'b0;
        flush_evt      = 1'b0;

        if (rst || (state == ST_INIT)) begin
            init_mode   = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            id_ctrl_out = '0;
            if (init_cnt == INIT_LAST) begin
                state_nxt    = ST_RUN;
                init_cnt_nxt = '0;
            end else begin
                init_cnt_nxt = init_cnt + INIT_W'(1);
            end
        end else if (mem_busy) begin
            state_nxt     = ST_MEM_WAIT;
            ret_state_nxt = eval_lu ? ST_LU_STALL : ST_RUN;
        end else if (ex_branch_taken) begin
            pc_en          = 1'b1;
            ifid_en        = 1'b1;
            idex_en        = 1'b1;
            exmem_en       = 1'b1;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            flush_evt      = 1'b1;
            state_nxt      = ST_RUN;
            bubble_cnt_nxt = '0;
        end else if (eval_lu || load_use) begin
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            id_ctrl_out = '0;
            if (eval_lu) begin
                if (bubble_inc >= BUB_TOTAL) begin
                    state_nxt      = ST_RUN;
                    bubble_cnt_nxt = '0;
                end else begin
                    state_nxt      = ST_LU_STALL;
                    bubble_cnt_nxt = bubble_inc;
                end
            end else if (LOAD_USE_BUBBLES > 1) begin
                state_nxt      = ST_LU_STALL;
                bubble_cnt_nxt = BUB_W'(1);
            end else begin
                state_nxt      = ST_RUN;
                bubble_cnt_nxt = '0;
            end
        end else begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            ret_state    <= ST_RUN;
            init_cnt     <= '0;
            bubble_cnt   <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state      <= state_nxt;
            ret_state  <= ret_state_nxt;
            init_cnt   <= init_cnt_nxt;
            bubble_cnt <= bubble_cnt_nxt;
            if (!init_mode && !pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_evt && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    // EX holds a bubble during LU_STALL, so a taken branch there is an upstream bug.
    always_ff @(posedge clk) begin
        if (!rst && eval_lu && !mem_busy) begin
            assert (!ex_branch_taken);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module : tb_hazard_controller
// Brief  : Randomized bench for hazard_controller against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

    localparam int INIT_N = 2;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic [8:0] id_ctrl_in;
    logic       ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write, mem_busy;

    logic       pc_en_o[2], ifid_en_o[2], idex_en_o[2], exmem_en_o[2];
    logic       ifid_flush_o[2], idex_flush_o[2];
    logic [8:0] ctrl_o[2];
    logic [1:0] fwd_a_o[2], fwd_b_o[2];
    logic [15:0] stall0, flush0;
    logic [3:0]  stall1, flush1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: remaining init cycles, remaining bubbles, counters.
    int          init_left[2];
    int          bub_left[2];
    int unsigned stall_m[2];
    int unsigned flush_m[2];
    int          lub[2]    = '{1, 2};
    int unsigned cmax[2]   = '{32'hFFFF, 32'hF};

    hazard_controller #(.INIT_CYCLES(INIT_N), .LOAD_USE_BUBBLES(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_ctrl_in(id_ctrl_in),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken), .mem_reg_write(mem_reg_write),
        .mem_write_reg(mem_write_reg), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .mem_busy(mem_busy), .pc_en(pc_en_o[0]), .ifid_en(ifid_en_o[0]), .idex_en(idex_en_o[0]),
        .exmem_en(exmem_en_o[0]), .ifid_flush(ifid_flush_o[0]), .idex_flush(idex_flush_o[0]),
        .id_ctrl_out(ctrl_o[0]), .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]),
        .stall_cycles(stall0), .flush_count(flush0)
    );

    hazard_controller #(.INIT_CYCLES(INIT_N), .LOAD_USE_BUBBLES(2), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_ctrl_in(id_ctrl_in),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken), .mem_reg_write(mem_reg_write),
        .mem_write_reg(mem_write_reg), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .mem_busy(mem_busy), .pc_en(pc_en_o[1]), .ifid_en(ifid_en_o[1]), .idex_en(idex_en_o[1]),
        .exmem_en(exmem_en_o[1]), .ifid_flush(ifid_flush_o[1]), .idex_flush(idex_flush_o[1]),
        .id_ctrl_out(ctrl_o[1]), .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]),
        .stall_cycles(stall1), .flush_count(flush1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (mem_reg_write && mem_write_reg != 0 && mem_write_reg == src) return 2'b10;
        if (wb_reg_write && wb_write_reg != 0 && wb_write_reg == src) return 2'b01;
        return 2'b00;
    endfunction

    // Computes expected outputs for this cycle's inputs and advances the model across the edge.
    task automatic model_eval(input int i, output logic [5:0] flags, output logic [8:0] ctrl,
                              output logic [1:0] fa, output logic [1:0] fb);
        logic lu;
        lu = ex_mem_read && ex_write_reg != 0 &&
             (ex_write_reg == id_rs ||
              (ex_write_reg == id_rt && (id_ctrl_in[8] | id_ctrl_in[3] | id_ctrl_in[2])));
        flags = 6'b000011; ctrl = 9'd0; fa = 2'b00; fb = 2'b00;
        if (rst) begin
            init_left[i] = INIT_N; bub_left[i] = 0; stall_m[i] = 0; flush_m[i] = 0;
        end else if (init_left[i] > 0) begin
            init_left[i]--;
        end else begin
            fa = fwd_ref(ex_rs);
            fb = fwd_ref(ex_rt);
            if (mem_busy) begin
                flags = 6'b000000; ctrl = id_ctrl_in;
                if (stall_m[i] < cmax[i]) stall_m[i]++;
            end else if (ex_branch_taken) begin
                flags = 6'b111111; ctrl = id_ctrl_in; bub_left[i] = 0;
                if (flush_m[i] < cmax[i]) flush_m[i]++;
            end else if (bub_left[i] > 0 || lu) begin
                flags = 6'b001100; ctrl = 9'd0;
                bub_left[i] = (bub_left[i] > 0) ? bub_left[i] - 1 : lub[i] - 1;
                if (stall_m[i] < cmax[i]) stall_m[i]++;
            end else begin
                flags = 6'b111100; ctrl = id_ctrl_in;
            end
        end
    endtask

    task automatic step();
        logic [5:0] ef;
        logic [8:0] ec;
        logic [1:0] ea, eb;
        #1;
        for (int i = 0; i < 2; i++) begin
            model_eval(i, ef, ec, ea, eb);
            check($sformatf("flags%0d", i),
                  {pc_en_o[i], ifid_en_o[i], idex_en_o[i], exmem_en_o[i], ifid_flush_o[i], idex_flush_o[i]}, ef);
            check($sformatf("ctrl%0d", i), ctrl_o[i], ec);
            check($sformatf("fwd%0d", i), {fwd_a_o[i], fwd_b_o[i]}, {ea, eb});
        end
        @(posedge clk);
        #1;
        check("stall0", stall0, stall_m[0]);
        check("flush0", flush0, flush_m[0]);
        check("stall1", stall1, stall_m[1]);
        check("flush1", flush1, flush_m[1]);
    endtask

    task automatic clear_inputs();
        rst = 1'b0; id_rs = 0; id_rt = 0; id_ctrl_in = 0; ex_rs = 0; ex_rt = 0;
        ex_mem_read = 0; ex_write_reg = 0; ex_branch_taken = 0; mem_reg_write = 0;
        mem_write_reg = 0; wb_reg_write = 0; wb_write_reg = 0; mem_busy = 0;
    endtask

    task automatic set_lw8(input logic [4:0] rs, input logic [4:0] rt, input logic [8:0] ctrl);
        clear_inputs();
        ex_mem_read = 1; ex_write_reg = 5'd8; id_rs = rs; id_rt = rt; id_ctrl_in = ctrl;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) step();
        clear_inputs();
        repeat (4) step();

        // lw $8 followed by add using $8
        set_lw8(5'd8, 5'd2, 9'b100100010); step();
        clear_inputs(); repeat (2) step();
        // sw with rt=$8 stalls, addi with rt=$8 does not
        set_lw8(5'd3, 5'd8, 9'b010001000); step();
        clear_inputs(); repeat (2) step();
        set_lw8(5'd3, 5'd8, 9'b010100000); step();
        clear_inputs(); step();
        // taken branch overrides a pending load-use
        set_lw8(5'd8, 5'd8, 9'b100100010); ex_branch_taken = 1; step();
        clear_inputs(); step();
        // memory freeze in the middle of a two-bubble stall
        set_lw8(5'd8, 5'd0, 9'b100100010); step();
        clear_inputs(); mem_busy = 1; repeat (4) step();
        clear_inputs(); repeat (2) step();
        // forwarding priority
        mem_reg_write = 1; wb_reg_write = 1; mem_write_reg = 5; wb_write_reg = 5; ex_rs = 5; ex_rt = 5;
        step();
        mem_write_reg = 0; step();
        // reset in the middle of a stall
        set_lw8(5'd8, 5'd0, 9'b100100010); step();
        clear_inputs(); rst = 1; step();
        clear_inputs(); repeat (4) step();

        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 79) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_ctrl_in      = 9'($urandom);
            ex_rs           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom);
            ex_write_reg    = 5'($urandom_range(0, 3));
            mem_reg_write   = 1'($urandom);
            mem_write_reg   = 5'($urandom_range(0, 3));
            wb_reg_write    = 1'($urandom);
            wb_write_reg    = 5'($urandom_range(0, 3));
            mem_busy        = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0) && (bub_left[1] == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
